// File: rtl/nios_sys_pio_switch_in_if.sv
// Avalon-MM slave bus bundle for the switch-input PIO: register access plus the level interrupt.
// The master side drives the request fields and observes readdata and irq.
interface nios_sys_pio_switch_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );
endinterface

// File: rtl/nios_sys_pio_switch_in.sv
// Debounced switch-input PIO: synchronizes and debounces external pins, captures edges and
// raises a masked level interrupt, all visible through a four-register Avalon-MM slave.
module nios_sys_pio_switch_in #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned EDGE_TYPE       = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [WIDTH-1:0]          in_port,
   nios_sys_pio_switch_in_if.slave   bus
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]           meta_q;
   logic [WIDTH-1:0]           sync_q;
   logic [WIDTH-1:0]           deb_q, deb_d;
   logic [WIDTH-1:0]           deb_dly_q;
   logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]           irqmask_q, irqmask_d;
   logic [WIDTH-1:0]           edgecapture_q, edgecapture_d;
   logic [WIDTH-1:0]           edge_hit;
   logic [WIDTH-1:0]           ecap_clr;
   logic                       wr_en;

   // Two-flop synchronizer; nothing else looks at in_port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= in_port;
         sync_q <= meta_q;
      end
   end

   // A bit flips only after disagreeing with its debounced level for DEBOUNCE_CYCLES clocks.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (sync_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            deb_d[i] = sync_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_hit = deb_q & ~deb_dly_q;
         1:       edge_hit = ~deb_q & deb_dly_q;
         default: edge_hit = deb_q ^ deb_dly_q;
      endcase
   end

   assign wr_en = bus.chipselect & ~bus.write_n;

   always_comb begin
      irqmask_d = irqmask_q;
      ecap_clr  = '0;
      if (wr_en && (bus.address == 2'd2)) begin
         irqmask_d = bus.writedata[WIDTH-1:0];
      end
      if (wr_en && (bus.address == 2'd3)) begin
         ecap_clr = bus.writedata[WIDTH-1:0];
      end
      // Set takes priority over a same-cycle clear so no edge is lost.
      edgecapture_d = (edgecapture_q & ~ecap_clr) | edge_hit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q         <= '0;
         deb_dly_q     <= '0;
         cnt_q         <= '0;
         irqmask_q     <= '0;
         edgecapture_q <= '0;
      end else begin
         deb_q         <= deb_d;
         deb_dly_q     <= deb_q;
         cnt_q         <= cnt_d;
         irqmask_q     <= irqmask_d;
         edgecapture_q <= edgecapture_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata[WIDTH-1:0] = deb_q;
         2'd2:    bus.readdata[WIDTH-1:0] = irqmask_q;
         2'd3:    bus.readdata[WIDTH-1:0] = edgecapture_q;
         default: bus.readdata = '0;
      endcase
   end

   assign bus.irq = |(edgecapture_q & irqmask_q);

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = ^bus.writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_nios_sys_pio_switch_in.sv
// Randomized bench for the switch-input PIO: two instances (rising and any-edge capture) share
// stimulus and are compared every cycle against a behavioural model, plus literal scenario checks.
module tb_nios_sys_pio_switch_in;
   localparam int W = 4;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  in_port = '0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;

   int n_chk  = 0;
   int n_pass = 0;

   nios_sys_pio_switch_in_if bus_a ();
   nios_sys_pio_switch_in_if bus_b ();

   assign bus_a.address    = address;
   assign bus_a.chipselect = chipselect;
   assign bus_a.write_n    = write_n;
   assign bus_a.writedata  = writedata;
   assign bus_b.address    = address;
   assign bus_b.chipselect = chipselect;
   assign bus_b.write_n    = write_n;
   assign bus_b.writedata  = writedata;

   nios_sys_pio_switch_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus_a.slave)
   );

   nios_sys_pio_switch_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus_b.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model: pins seen two clocks late; a level is accepted after D disagreeing clocks.
   logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_mask;
   logic [W-1:0] m_ecap [2];
   int           m_run [W];

   function automatic logic [31:0] m_rd(input logic [1:0] a, input int k);
      logic [31:0] r;
      r = '0;
      if (a == 2'd0) r[W-1:0] = m_deb;
      if (a == 2'd2) r[W-1:0] = m_mask;
      if (a == 2'd3) r[W-1:0] = m_ecap[k];
      return r;
   endfunction

   task automatic m_clear();
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0; m_mask = '0;
      m_ecap[0] = '0; m_ecap[1] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   initial begin
      logic [W-1:0] rise, fall, clr;
      m_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_clear();
         end else begin
            rise = m_deb & ~m_prev;
            fall = ~m_deb & m_prev;
            clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            m_ecap[0] = (m_ecap[0] & ~clr) | rise;
            m_ecap[1] = (m_ecap[1] & ~clr) | rise | fall;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_prev = m_deb;
            for (int i = 0; i < W; i++) begin
               if (m_s2[i] != m_deb[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == D) begin
                     m_deb[i] = m_s2[i];
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_s2 = m_s1;
            m_s1 = in_port;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("readdata_a", bus_a.readdata, m_rd(address, 0));
         chk("readdata_b", bus_b.readdata, m_rd(address, 1));
         chk("irq_a", {31'b0, bus_a.irq}, {31'b0, |(m_ecap[0] & m_mask)});
         chk("irq_b", {31'b0, bus_b.irq}, {31'b0, |(m_ecap[1] & m_mask)});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cyc(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string name, input bit sel_b, input logic [1:0] a,
                         input logic [31:0] exp);
      address = a;
      #1;
      chk(name, sel_b ? bus_b.readdata : bus_a.readdata, exp);
   endtask

   initial begin
      cyc(3);
      for (int a = 0; a < 4; a++) rd_chk("reset_read", 1'b0, 2'(a), 32'h0);
      chk("reset_irq", {31'b0, bus_a.irq}, 32'h0);
      reset_n = 1'b1;
      cyc(2);

      // Rising edge on bit0: data at edge 5, capture one clock later, irq masked off.
      in_port = 4'b0001;
      cyc(5);
      rd_chk("data_before_edge5", 1'b0, 2'd0, 32'h0);
      cyc(1);
      rd_chk("data_edge5", 1'b0, 2'd0, 32'h1);
      rd_chk("ecap_edge5", 1'b0, 2'd3, 32'h0);
      cyc(1);
      rd_chk("ecap_edge6", 1'b0, 2'd3, 32'h1);
      chk("irq_masked", {31'b0, bus_a.irq}, 32'h0);

      // Three-cycle glitch must be rejected.
      in_port = 4'b0000;
      cyc(8);
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h1);
      in_port = 4'b0001;
      cyc(3);
      in_port = 4'b0000;
      cyc(8);
      rd_chk("glitch_data", 1'b0, 2'd0, 32'h0);
      rd_chk("glitch_ecap", 1'b0, 2'd3, 32'h0);
      chk("glitch_irq", {31'b0, bus_a.irq}, 32'h0);

      // Pending bit2 with full mask; write-0 is a no-op, write-1 clears.
      wr(2'd2, 32'hF);
      in_port = 4'b0100;
      cyc(7);
      chk("pending_irq", {31'b0, bus_a.irq}, 32'h1);
      rd_chk("pending_ecap", 1'b0, 2'd3, 32'h4);
      wr(2'd3, 32'h0);
      rd_chk("w0_ecap", 1'b0, 2'd3, 32'h4);
      chk("w0_irq", {31'b0, bus_a.irq}, 32'h1);
      wr(2'd3, 32'h4);
      rd_chk("clr_ecap", 1'b0, 2'd3, 32'h0);
      chk("clr_irq", {31'b0, bus_a.irq}, 32'h0);

      // Clear of bit1 on the same clock its edge is captured: set wins.
      in_port = 4'b0110;
      cyc(6);
      wr(2'd3, 32'h2);
      rd_chk("set_wins_ecap", 1'b0, 2'd3, 32'h2);
      chk("set_wins_irq", {31'b0, bus_a.irq}, 32'h1);

      // Reset in the middle of a bit0 debounce count.
      in_port = 4'b0111;
      cyc(4);
      reset_n = 1'b0;
      #1;
      chk("rst_irq", {31'b0, bus_a.irq}, 32'h0);
      for (int a = 0; a < 4; a++) rd_chk("rst_mid_read", 1'b0, 2'(a), 32'h0);
      cyc(2);
      reset_n = 1'b1;
      cyc(5);
      rd_chk("recap_data_early", 1'b0, 2'd0, 32'h0);
      cyc(1);
      rd_chk("recap_data", 1'b0, 2'd0, 32'h7);
      rd_chk("recap_ecap_early", 1'b0, 2'd3, 32'h0);
      cyc(1);
      rd_chk("recap_ecap", 1'b0, 2'd3, 32'h7);
      chk("recap_irq", {31'b0, bus_a.irq}, 32'h0);

      // Any-edge instance: bit3 up then down, each captured and cleared separately.
      wr(2'd3, 32'hF);
      in_port = 4'b1111;
      cyc(10);
      rd_chk("any_rise", 1'b1, 2'd3, 32'h8);
      wr(2'd3, 32'h8);
      rd_chk("any_rise_clr", 1'b1, 2'd3, 32'h0);
      in_port = 4'b0111;
      cyc(10);
      rd_chk("any_fall", 1'b1, 2'd3, 32'h8);
      wr(2'd3, 32'h8);
      rd_chk("any_fall_clr", 1'b1, 2'd3, 32'h0);

      // Random pins, reads and writes, with one reset pulse.
      for (int c = 0; c < 3000; c++) begin
         chipselect = 1'b0;
         write_n    = 1'b1;
         if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
         address = 2'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            writedata  = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            chipselect = 1'b1;
         end
         if (c == 1500) reset_n = 1'b0;
         if (c == 1503) reset_n = 1'b1;
         cyc(1);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
